// File: rtl/mem_request_arbiter.sv
// Shares one memory port between instruction fetch and data load/store.
// A data access goes first, then the fetch, then a one-cycle RELEASE
// lets the core advance. Misaligned data accesses skip the bus entirely.
// A bus access with no mem_ready within TIMEOUT_CYC cycles is abandoned
// and raises the sticky bus_err flag.
module mem_request_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              imemRen,
  input  logic [ADDR_W-1:0] imemaddr,
  input  logic              dmmRen,
  input  logic              dmmWen,
  input  logic [1:0]        dmm_size,
  input  logic              dmm_unsigned,
  input  logic [ADDR_W-1:0] dmmaddr,
  input  logic [31:0]       dmmstore,
  output logic [31:0]       imemload,
  output logic [31:0]       dmmload,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, DREQ, IREQ, RELEASE} state_t;

  localparam logic [7:0]        TO_LAST   = 8'(TIMEOUT_CYC - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_t            state;
  logic              d_done;
  logic [7:0]        tcnt;

  logic              data_req;
  logic              is_load;
  logic              misaligned;
  logic              timeout_hit;
  logic [ADDR_W-1:0] dword_addr;
  logic [ADDR_W-1:0] iword_addr;
  logic [3:0]        store_be;
  logic [31:0]       store_data;
  logic [31:0]       shifted;
  logic [31:0]       load_value;

  assign data_req    = dmmRen | dmmWen;
  assign is_load     = dmmRen & ~dmmWen;
  assign timeout_hit = (tcnt == TO_LAST);
  assign dword_addr  = dmmaddr & WORD_MASK;
  assign iword_addr  = imemaddr & WORD_MASK;

  // Request decode: alignment check, store lane steering, load extraction
  always_comb begin
    misaligned = 1'b0;
    store_be   = 4'b1111;
    store_data = dmmstore;
    shifted    = mem_rdata >> {dmmaddr[1:0], 3'b000};
    load_value = shifted;
    case (dmm_size)
      2'b00: begin
        store_be   = 4'b0001 << dmmaddr[1:0];
        store_data = {4{dmmstore[7:0]}};
        load_value = {{24{~dmm_unsigned & shifted[7]}}, shifted[7:0]};
      end
      2'b01: begin
        misaligned = dmmaddr[0];
        store_be   = 4'b0011 << {dmmaddr[1], 1'b0};
        store_data = {2{dmmstore[15:0]}};
        load_value = {{16{~dmm_unsigned & shifted[15]}}, shifted[15:0]};
      end
      default: misaligned = (dmmaddr[1:0] != 2'b00);
    endcase
  end

  // Stall the core whenever an access is in flight or about to start
  always_comb begin
    stall = 1'b0;
    case (state)
      DREQ, IREQ: stall = 1'b1;
      IDLE:       stall = imemRen | data_req;
      default:    stall = 1'b0;
    endcase
  end

  // Arbitration FSM with registered port strobes and result capture
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      d_done    <= 1'b0;
      tcnt      <= '0;
      mem_ren   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      imemload  <= '0;
      dmmload   <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      misalign <= 1'b0;
      case (state)
        IDLE: begin
          if (data_req && !d_done) begin
            if (misaligned) begin
              state    <= RELEASE;
              misalign <= 1'b1;
            end else begin
              state     <= DREQ;
              tcnt      <= '0;
              mem_ren   <= is_load;
              mem_wen   <= dmmWen;
              mem_addr  <= dword_addr;
              mem_be    <= dmmWen ? store_be : 4'b1111;
              mem_wdata <= dmmWen ? store_data : '0;
            end
          end else if (imemRen || data_req) begin
            state     <= IREQ;
            tcnt      <= '0;
            mem_ren   <= 1'b1;
            mem_wen   <= 1'b0;
            mem_addr  <= iword_addr;
            mem_be    <= 4'b1111;
            mem_wdata <= '0;
          end
        end
        DREQ: begin
          if (mem_ready) begin
            if (is_load) dmmload <= load_value;
            d_done <= 1'b1;
            if (imemRen) begin
              state     <= IREQ;
              tcnt      <= '0;
              mem_ren   <= 1'b1;
              mem_wen   <= 1'b0;
              mem_addr  <= iword_addr;
              mem_be    <= 4'b1111;
              mem_wdata <= '0;
            end else begin
              state   <= RELEASE;
              mem_ren <= 1'b0;
              mem_wen <= 1'b0;
            end
          end else if (timeout_hit) begin
            bus_err <= 1'b1;
            if (is_load) dmmload <= '0;
            state   <= RELEASE;
            mem_ren <= 1'b0;
            mem_wen <= 1'b0;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        IREQ: begin
          if (mem_ready) begin
            imemload <= mem_rdata;
            state    <= RELEASE;
            mem_ren  <= 1'b0;
          end else if (timeout_hit) begin
            bus_err  <= 1'b1;
            imemload <= '0;
            state    <= RELEASE;
            mem_ren  <= 1'b0;
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        default: begin
          d_done <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter. Each transaction task plans the
// per-cycle bus schedule from the access rules and publishes the expected
// outputs; a negedge compare process checks the DUT against them.
module tb_mem_request_arbiter;
  localparam int unsigned TO = 4;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        imemRen = 1'b0;
  logic [31:0] imemaddr = '0;
  logic        dmmRen = 1'b0;
  logic        dmmWen = 1'b0;
  logic [1:0]  dmm_size = '0;
  logic        dmm_unsigned = 1'b0;
  logic [31:0] dmmaddr = '0;
  logic [31:0] dmmstore = '0;
  logic [31:0] imemload;
  logic [31:0] dmmload;
  logic        stall;
  logic        misalign;
  logic        bus_err;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;

  mem_request_arbiter #(.ADDR_W(32), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .nRST(nRST), .imemRen(imemRen), .imemaddr(imemaddr),
    .dmmRen(dmmRen), .dmmWen(dmmWen), .dmm_size(dmm_size),
    .dmm_unsigned(dmm_unsigned), .dmmaddr(dmmaddr), .dmmstore(dmmstore),
    .imemload(imemload), .dmmload(dmmload), .stall(stall),
    .misalign(misalign), .bus_err(bus_err), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad = 0;

  bit          exp_valid = 1'b0;
  logic        exp_stall, exp_ren, exp_wen, exp_mis;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_be;
  logic [31:0] m_imemload = '0;
  logic [31:0] m_dmmload = '0;
  logic        m_bus_err = 1'b0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_valid) begin
      chk1("stall", stall, exp_stall);
      chk1("mem_ren", mem_ren, exp_ren);
      chk1("mem_wen", mem_wen, exp_wen);
      chk1("misalign", misalign, exp_mis);
      chk1("bus_err", bus_err, m_bus_err);
      chk32("imemload", imemload, m_imemload);
      chk32("dmmload", dmmload, m_dmmload);
      if (exp_ren || exp_wen) begin
        chk32("mem_addr", mem_addr, exp_addr);
        chk32("mem_be", {28'b0, mem_be}, {28'b0, exp_be});
        if (exp_wen) chk32("mem_wdata", mem_wdata, exp_wdata);
      end
    end
  end

  function automatic int unsigned nbytes_of(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  // Byte lanes [lane, lane+n) of the read word, extended to 32 bits
  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] size,
                                             input bit uns, input logic [31:0] a);
    int unsigned lane;
    int unsigned n;
    logic [31:0] r;
    lane = 32'(a[1:0]);
    n = nbytes_of(size);
    r = '0;
    for (int unsigned i = 0; i < n; i++) r[8*i +: 8] = rd[8*(lane+i) +: 8];
    if (!uns && n < 4 && r[8*n-1])
      for (int unsigned i = n; i < 4; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] size, input logic [31:0] a);
    int unsigned lane;
    int unsigned n;
    logic [3:0] be;
    lane = 32'(a[1:0]);
    n = nbytes_of(size);
    be = '0;
    for (int unsigned i = 0; i < 4; i++) be[i] = (i >= lane) && (i < lane + n);
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] st);
    int unsigned n;
    logic [31:0] w;
    n = nbytes_of(size);
    w = '0;
    for (int unsigned i = 0; i < 4; i++) w[8*i +: 8] = st[8*(i % n) +: 8];
    return w;
  endfunction

  task automatic set_exp(input logic s, input logic r, input logic w, input logic m,
                         input logic [31:0] a, input logic [3:0] b, input logic [31:0] wd);
    exp_stall = s; exp_ren = r; exp_wen = w; exp_mis = m;
    exp_addr = a; exp_be = b; exp_wdata = wd;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    imemRen = 1'b0; dmmRen = 1'b0; dmmWen = 1'b0; mem_ready = 1'b0;
    exp_valid = 1'b1;
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    for (int i = 0; i < n; i++) step();
  endtask

  // One core instruction: optional data access (dwait<0 means mem_ready never
  // comes), optional fetch, ending with the RELEASE cycle.
  task automatic run_txn(input bit fetch, input logic [31:0] iaddr, input logic [31:0] irdata,
                         input int iwait, input bit ld, input bit st, input logic [1:0] size,
                         input bit uns, input logic [31:0] daddr, input logic [31:0] sdata,
                         input logic [31:0] drdata, input int dwait);
    bit data;
    bit mis;
    int n;
    data = ld | st;
    mis = (32'(daddr[1:0]) % nbytes_of(size)) != 0;
    imemRen = fetch; imemaddr = iaddr; dmmRen = ld; dmmWen = st; dmm_size = size;
    dmm_unsigned = uns; dmmaddr = daddr; dmmstore = sdata;
    mem_ready = 1'b0; mem_rdata = ~drdata;
    exp_valid = 1'b1;
    set_exp(fetch | data, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
    if (data && mis) begin
      set_exp(1'b0, 1'b0, 1'b0, 1'b1, '0, '0, '0);
      step();
      return;
    end
    if (data) begin
      n = (dwait < 0) ? int'(TO) : dwait + 1;
      for (int k = 0; k < n; k++) begin
        mem_ready = (k == dwait);
        mem_rdata = (k == dwait) ? drdata : ~drdata;
        set_exp(1'b1, ld & ~st, st, 1'b0, daddr & ~32'h3,
                st ? model_be(size, daddr) : 4'hF, model_wdata(size, sdata));
        step();
      end
      mem_ready = 1'b0;
      if (dwait < 0) begin
        m_bus_err = 1'b1;
        if (ld && !st) m_dmmload = '0;
        set_exp(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        step();
        return;
      end
      if (ld && !st) m_dmmload = model_load(drdata, size, uns, daddr);
    end
    if (fetch) begin
      for (int k = 0; k <= iwait; k++) begin
        mem_ready = (k == iwait);
        mem_rdata = (k == iwait) ? irdata : ~irdata;
        set_exp(1'b1, 1'b1, 1'b0, 1'b0, iaddr & ~32'h3, 4'hF, '0);
        step();
      end
      mem_ready = 1'b0;
      m_imemload = irdata;
    end
    set_exp(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk1("rst_stall", stall, 1'b0);
    chk1("rst_ren", mem_ren, 1'b0);
    chk1("rst_wen", mem_wen, 1'b0);
    chk32("rst_be", {28'b0, mem_be}, 32'h0);
    chk32("rst_addr", mem_addr, 32'h0);
    chk32("rst_wdata", mem_wdata, 32'h0);
    chk32("rst_imemload", imemload, 32'h0);
    chk32("rst_dmmload", dmmload, 32'h0);
    chk1("rst_misalign", misalign, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    step();
    nRST = 1'b1;
    idle_cycles(2);

    // fetch only, zero-wait
    run_txn(1, 32'h12341234, 32'hDEADBEEF, 0, 0, 0, 2'b00, 0, '0, '0, '0, 0);
    chk32("lit_fetch", imemload, 32'hDEADBEEF);
    // LB signed / unsigned with trailing fetch
    run_txn(1, 32'h00000100, 32'h11112222, 0, 1, 0, 2'b00, 0, 32'h00010001, '0, 32'h00008000, 0);
    chk32("lit_lb", dmmload, 32'hFFFFFF80);
    run_txn(1, 32'h00000104, 32'h33334444, 1, 1, 0, 2'b00, 1, 32'h00010001, '0, 32'h00008000, 0);
    chk32("lit_lbu", dmmload, 32'h00000080);
    // SH upper half, SB top lane, LH signed, LW, size 11 load
    run_txn(1, 32'h00000108, 32'h55556666, 0, 0, 1, 2'b01, 0, 32'h00000002, 32'hABCDABCD, '0, 1);
    run_txn(0, '0, '0, 0, 0, 1, 2'b00, 0, 32'h00000203, 32'h000000A5, '0, 0);
    run_txn(0, '0, '0, 0, 1, 0, 2'b01, 0, 32'h00000302, '0, 32'h80010000, 2);
    chk32("lit_lh", dmmload, 32'hFFFF8001);
    run_txn(1, 32'h0000010C, 32'h77778888, 2, 1, 0, 2'b10, 0, 32'h00000020, '0, 32'hCAFEF00D, 0);
    run_txn(0, '0, '0, 0, 1, 0, 2'b11, 1, 32'h00000004, '0, 32'h01234567, 1);
    chk32("lit_lw11", dmmload, 32'h01234567);
    // misaligned SW, then the fetch; misaligned LH leaves dmmload alone
    run_txn(1, 32'h00000110, 32'h9999AAAA, 0, 0, 1, 2'b10, 0, 32'h01010101, 32'h12345678, '0, 0);
    run_txn(1, 32'h00000110, 32'h9999AAAA, 0, 0, 0, 2'b00, 0, '0, '0, '0, 0);
    run_txn(0, '0, '0, 0, 1, 0, 2'b01, 0, 32'h00000001, '0, 32'hFFFFFFFF, 0);
    chk32("lit_mis_keep", dmmload, 32'h01234567);
    idle_cycles(2);

    // load that never completes
    run_txn(1, 32'h00000114, 32'hBBBBCCCC, 0, 1, 0, 2'b10, 0, 32'h00000040, '0, 32'h5A5A5A5A, -1);
    chk1("lit_bus_err", bus_err, 1'b1);
    chk32("lit_to_load", dmmload, 32'h0);
    run_txn(1, 32'h00000118, 32'hDDDDEEEE, 1, 0, 0, 2'b00, 0, '0, '0, '0, 0);
    chk1("lit_bus_err_sticky", bus_err, 1'b1);

    // reset in the middle of a fetch
    imemRen = 1'b1; imemaddr = 32'h00000400; dmmRen = 1'b0; dmmWen = 1'b0;
    mem_ready = 1'b0; mem_rdata = 32'hFFFF0000;
    set_exp(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    step();
    set_exp(1'b1, 1'b1, 1'b0, 1'b0, 32'h00000400, 4'hF, '0);
    #2;
    chk1("lit_ren_inflight", mem_ren, 1'b1);
    exp_valid = 1'b0;
    nRST = 1'b0;
    #1;
    chk1("mid_rst_ren", mem_ren, 1'b0);
    chk1("mid_rst_wen", mem_wen, 1'b0);
    chk32("mid_rst_be", {28'b0, mem_be}, 32'h0);
    chk32("mid_rst_addr", mem_addr, 32'h0);
    chk32("mid_rst_imemload", imemload, 32'h0);
    chk32("mid_rst_dmmload", dmmload, 32'h0);
    chk1("mid_rst_bus_err", bus_err, 1'b0);
    m_bus_err = 1'b0; m_imemload = '0; m_dmmload = '0;
    step();
    nRST = 1'b1;
    run_txn(1, 32'h00000400, 32'h0BADF00D, 1, 0, 0, 2'b00, 0, '0, '0, '0, 0);
    chk32("lit_post_rst_fetch", imemload, 32'h0BADF00D);
    idle_cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_request_arbiter.md
MEM_REQUEST_ARBITER -- requirements
Module: mem_request_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32: width of all address ports.
REQ-002 Parameter TIMEOUT_CYC, default 16: number of cycles a bus access waits for mem_ready; legal range 1..255.
REQ-003 CLK  in  1  system clock; all state updates on rising edge.
REQ-004 nRST  in  1  asynchronous, active-low reset.
REQ-005 imemRen  in  1  core requests an instruction fetch this instruction.
REQ-006 imemaddr  in  ADDR_W  fetch address, word aligned.
REQ-007 dmmRen / dmmWen  in  1 each  core data load / store request.
REQ-008 dmm_size  in  2  access size: 00 byte, 01 half, 10 word; 11 is treated as word.
REQ-009 dmm_unsigned  in  1  load result is zero-extended when 1 and sign-extended when 0.
REQ-010 dmmaddr  in  ADDR_W  data byte address.
REQ-011 dmmstore  in  32  store data, right-aligned.
REQ-012 imemload / dmmload  out  32  captured fetch word / extended load result.
REQ-013 stall  out  1  core must hold PC and inputs while high.
REQ-014 misalign  out  1  one-cycle pulse when a data access is misaligned.
REQ-015 bus_err  out  1  sticky timeout flag.
REQ-016 mem_ren / mem_wen  out  1 each  shared memory port strobes, registered.
REQ-017 mem_addr  out  ADDR_W  word address on the port, with bits [1:0] forced to 00.
REQ-018 mem_wdata  out  32; mem_be  out  4; mem_rdata  in  32; mem_ready  in  1  one-cycle completion.

Function
REQ-019 The FSM SHALL have four states, IDLE, DREQ, IREQ and RELEASE, with a registered d_done flag and a timeout counter.
REQ-020 In IDLE with a data request (dmmRen|dmmWen) and d_done=0, the FSM SHALL go to DREQ if aligned, or to RELEASE with misalign=1 if misaligned, with no bus access.
REQ-021 In IDLE with only imemRen, or with d_done=1, the FSM SHALL go to IREQ; with no request it SHALL stay in IDLE.
REQ-022 Misaligned is defined as half with addr[0]=1, or word with addr[1:0]!=00.
REQ-023 In DREQ the block SHALL drive mem_ren=dmmRen&~dmmWen and mem_wen=dmmWen, because dmmWen has priority when both are high.
REQ-024 When mem_ready is seen in DREQ, the block SHALL register dmmload, set d_done, and go to IREQ if imemRen is high, else to RELEASE.
REQ-025 In IREQ the block SHALL drive mem_ren=1 with mem_addr=imemaddr; on mem_ready it SHALL register imemload=mem_rdata and go to RELEASE.
REQ-026 RELEASE SHALL last exactly one cycle with stall=0, then clear d_done and return to IDLE.
REQ-027 stall SHALL be combinational: 1 in DREQ and IREQ, and 1 in IDLE while any request is present; 0 otherwise.
REQ-028 Minimum latency SHALL be: fetch only, IDLE->IREQ->RELEASE (3 cycles with zero-wait memory); data+fetch, 4 cycles.
REQ-029 Store byte (size 00): mem_be=0001<<addr[1:0] and mem_wdata=byte replicated 4x.
REQ-030 Store half (size 01): mem_be=0011<<(2*addr[1]) and mem_wdata=half replicated 2x.
REQ-031 Store word: mem_be=1111.
REQ-032 Loads SHALL drive mem_be=1111.
REQ-033 The load result SHALL be mem_rdata>>(8*addr[1:0]), truncated to the access size and extended per dmm_unsigned.
REQ-034 The timeout counter SHALL reset on entry to DREQ/IREQ and increment each cycle without mem_ready.
REQ-035 When the timeout counter reaches TIMEOUT_CYC, bus_err SHALL be set, the pending load result SHALL be forced to 0, and the FSM SHALL go to RELEASE.
REQ-036 mem_ready SHALL be ignored in IDLE and RELEASE.
REQ-037 A misaligned access SHALL leave dmmload unchanged.
REQ-038 misalign SHALL be high only during the RELEASE cycle that follows detection.

Reset
REQ-039 nRST low SHALL immediately force: state IDLE, d_done=0, counter=0, mem_ren=mem_wen=0, mem_be=0, mem_addr=0, mem_wdata=0, imemload=dmmload=0, misalign=0, bus_err=0.
REQ-040 Reset asserted mid-access SHALL abort the access with no completion.
REQ-041 After reset release, the FSM SHALL evaluate inputs on the first rising edge.
REQ-042 bus_err SHALL clear only on reset.

Verification
REQ-043 Fetch only: imemRen=1, imemaddr=0x12341234, mem_ready=1 in IREQ, mem_rdata=0xDEADBEEF -> imemload=0xDEADBEEF, stall high 2 cycles, low in RELEASE.
REQ-044 LB signed: dmmaddr=0x00010001, mem_rdata=0x0000_80_00 -> dmmload=0xFFFFFF80; with dmm_unsigned=1 -> 0x00000080; fetch follows the data access.
REQ-045 SH: dmmaddr=0x00000002, dmmstore=0xABCDABCD -> mem_wen=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x00000000.
REQ-046 SW misaligned at 0x01010101 -> no mem_wen, misalign pulse 1 cycle, then fetch proceeds normally.
REQ-047 mem_ready held 0 in DREQ with TIMEOUT_CYC=4 -> bus_err set after 4 cycles, dmmload=0, bus_err sticky until nRST.
REQ-048 Assert nRST low while mem_ren=1 in IREQ -> all outputs 0 immediately and state IDLE; clean fetch after release.
